// File: rtl/alu_pkg.sv
// Shared ALU op-code constants and the op-code type used by the issue queue and the ALU.
package alu_pkg;
  typedef logic [2:0] alucontrol_t;

  localparam alucontrol_t ALU_AND = 3'b000;
  localparam alucontrol_t ALU_OR  = 3'b001;
  localparam alucontrol_t ALU_ADD = 3'b010;
  localparam alucontrol_t ALU_SUB = 3'b110;
  localparam alucontrol_t ALU_SLT = 3'b111;
endpackage

// File: rtl/alu.sv
// Combinational ALU fed by the issue queue head; unknown op codes produce zero.
module alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  alucontrol_t      alucontrol,
  output logic [WIDTH-1:0] result,
  output logic             zero
);
  logic signed [WIDTH-1:0] a_s;
  logic signed [WIDTH-1:0] b_s;

  assign a_s = a;
  assign b_s = b;

  always_comb begin
    result = '0;
    case (alucontrol)
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_ADD: result = a + b;
      ALU_SUB: result = a - b;
      ALU_SLT: result = {{(WIDTH-1){1'b0}}, (a_s < b_s)};
      default: result = '0;
    endcase
  end

  assign zero = (result == '0);
endmodule

// File: rtl/alu_issue_queue.sv
// Registered FIFO of ALU operations; the head entry drives the ALU operands directly from storage.
module alu_issue_queue
  import alu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH-1:0]       in_a,
  input  logic [WIDTH-1:0]       in_b,
  input  alucontrol_t            in_alucontrol,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH-1:0]       a,
  output logic [WIDTH-1:0]       b,
  output alucontrol_t            alucontrol,
  output logic [$clog2(DEPTH):0] count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] a_mem_q  [DEPTH];
  logic [WIDTH-1:0] b_mem_q  [DEPTH];
  alucontrol_t      op_mem_q [DEPTH];
  logic             push, pop;

  // Status flags depend only on the registered count, so ready never follows out_ready.
  assign in_ready  = (count_q != CW'(DEPTH));
  assign out_valid = (count_q != '0);
  assign push      = in_valid & in_ready & ~flush;
  assign pop       = out_valid & out_ready & ~flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload storage is never reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      a_mem_q[wr_ptr_q]  <= in_a;
      b_mem_q[wr_ptr_q]  <= in_b;
      op_mem_q[wr_ptr_q] <= in_alucontrol;
    end
  end

  assign a          = out_valid ? a_mem_q[rd_ptr_q]  : '0;
  assign b          = out_valid ? b_mem_q[rd_ptr_q]  : '0;
  assign alucontrol = out_valid ? op_mem_q[rd_ptr_q] : ALU_AND;
  assign count      = count_q;
endmodule

// File: tb/tb_alu_issue_queue.sv
// Randomised bench for alu_issue_queue driving a downstream alu, checked against a queue-based model.
module tb_alu_issue_queue;
  import alu_pkg::*;

  localparam int DEPTH = 4;
  localparam int WIDTH = 32;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] in_a = '0;
  logic [31:0] in_b = '0;
  alucontrol_t in_alucontrol = ALU_AND;
  logic        in_ready, out_valid, zero;
  logic [31:0] a, b, result;
  alucontrol_t alucontrol;
  logic [2:0]  count;

  always #5 clk = ~clk;

  alu_issue_queue #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk(clk), .reset_n(reset_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_alucontrol(in_alucontrol),
    .out_valid(out_valid), .out_ready(out_ready),
    .a(a), .b(b), .alucontrol(alucontrol), .count(count)
  );

  alu #(.WIDTH(WIDTH)) u_alu (
    .a(a), .b(b), .alucontrol(alucontrol), .result(result), .zero(zero)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  op;
  } ent_t;

  ent_t mq[$];
  int   n_cmp = 0;
  int   n_err = 0;

  function automatic logic [31:0] ref_alu(input logic [31:0] x, input logic [31:0] y,
                                          input logic [2:0] op);
    case (op)
      3'b000:  return x & y;
      3'b001:  return x | y;
      3'b010:  return x + y;
      3'b110:  return x - y;
      3'b111:  return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  function automatic ent_t head_exp();
    ent_t e;
    e = '{32'd0, 32'd0, 3'd0};
    if (mq.size() != 0) e = mq[0];
    return e;
  endfunction

  // Drive one cycle of inputs, let the edge happen, update the model, return at the next negedge.
  task automatic cycle(input logic v, input logic [31:0] ia, input logic [31:0] ib,
                       input logic [2:0] op, input logic ordy, input logic fl);
    int sz;
    in_valid = v; in_a = ia; in_b = ib; in_alucontrol = op; out_ready = ordy; flush = fl;
    @(posedge clk);
    sz = mq.size();
    if (fl) mq.delete();
    else begin
      if (sz != 0 && ordy) void'(mq.pop_front());
      if (v && sz != DEPTH) mq.push_back('{ia, ib, op});
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    n_cmp++;
    if ({count, out_valid, in_ready, a, b, alucontrol} !== {3'd0, 1'b0, 1'b1, 64'd0, 3'd0}) begin
      n_err++;
      $display("FAIL reset_state: got cnt=%0d ov=%b ir=%b a=%h b=%h op=%b want 0 0 1 0 0 000",
               count, out_valid, in_ready, a, b, alucontrol);
    end
    #1 reset_n = 1'b1;
    cycle(1'b1, 32'h1234, 32'h5678, ALU_OR, 1'b0, 1'b0);
    n_cmp++;
    if ({count, a, result} !== {3'd1, 32'h1234, ref_alu(32'h1234, 32'h5678, ALU_OR)}) begin
      n_err++;
      $display("FAIL first_push_after_reset: got cnt=%0d a=%h res=%h want 1 00001234 %h",
               count, a, result, ref_alu(32'h1234, 32'h5678, ALU_OR));
    end
    cycle(1'b0, 32'd0, 32'd0, 3'd0, 1'b1, 1'b0);
  endtask

  task automatic test_slt();
    cycle(1'b1, 32'h0B, 32'h0B, ALU_SLT, 1'b1, 1'b0);
    n_cmp++;
    if ({out_valid, a, b, alucontrol, result, zero} !== {1'b1, 32'h0B, 32'h0B, 3'b111, 32'd0, 1'b1}) begin
      n_err++;
      $display("FAIL slt_head: got ov=%b a=%h b=%h op=%b res=%h z=%b want 1 0b 0b 111 0 1",
               out_valid, a, b, alucontrol, result, zero);
    end
    cycle(1'b0, 32'd0, 32'd0, 3'd0, 1'b1, 1'b0);
    n_cmp++;
    if ({count, out_valid} !== {3'd0, 1'b0}) begin
      n_err++;
      $display("FAIL slt_pop: got cnt=%0d ov=%b want 0 0", count, out_valid);
    end
  endtask

  task automatic test_full();
    ent_t exp[4];
    for (int i = 0; i < 4; i++) begin
      exp[i] = '{$urandom, $urandom, 3'($urandom)};
      cycle(1'b1, exp[i].a, exp[i].b, exp[i].op, 1'b0, 1'b0);
    end
    n_cmp++;
    if ({count, in_ready, out_valid} !== {3'd4, 1'b0, 1'b1}) begin
      n_err++;
      $display("FAIL full_flags: got cnt=%0d ir=%b ov=%b want 4 0 1", count, in_ready, out_valid);
    end
    cycle(1'b1, 32'hFF, 32'hFF, ALU_ADD, 1'b0, 1'b0);
    n_cmp++;
    if ({count, a} !== {3'd4, exp[0].a}) begin
      n_err++;
      $display("FAIL full_no_overwrite: got cnt=%0d a=%h want 4 %h", count, a, exp[0].a);
    end
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if ({a, b, alucontrol, result} !== {exp[i].a, exp[i].b, exp[i].op, ref_alu(exp[i].a, exp[i].b, exp[i].op)}) begin
        n_err++;
        $display("FAIL full_drain[%0d]: got a=%h b=%h op=%b res=%h want %h %h %b %h", i, a, b,
                 alucontrol, result, exp[i].a, exp[i].b, exp[i].op,
                 ref_alu(exp[i].a, exp[i].b, exp[i].op));
      end
      cycle(1'b0, 32'd0, 32'd0, 3'd0, 1'b1, 1'b0);
    end
    n_cmp++;
    if ({count, out_valid, a, b, alucontrol} !== {3'd0, 1'b0, 64'd0, 3'd0}) begin
      n_err++;
      $display("FAIL full_empty_after_drain: got cnt=%0d ov=%b a=%h b=%h op=%b want 0 0 0 0 0",
               count, out_valid, a, b, alucontrol);
    end
  endtask

  task automatic test_simul_and_flush();
    ent_t exp[4];
    for (int i = 0; i < 4; i++) exp[i] = '{$urandom, $urandom, 3'($urandom)};
    for (int i = 0; i < 3; i++) cycle(1'b1, exp[i].a, exp[i].b, exp[i].op, 1'b0, 1'b0);
    cycle(1'b1, exp[3].a, exp[3].b, exp[3].op, 1'b1, 1'b0);
    n_cmp++;
    if ({count, a, b, alucontrol} !== {3'd3, exp[1].a, exp[1].b, exp[1].op}) begin
      n_err++;
      $display("FAIL push_pop_same_cycle: got cnt=%0d a=%h b=%h op=%b want 3 %h %h %b",
               count, a, b, alucontrol, exp[1].a, exp[1].b, exp[1].op);
    end
    cycle(1'b0, 32'd0, 32'd0, 3'd0, 1'b1, 1'b0);
    n_cmp++;
    if ({count, a} !== {3'd2, exp[2].a}) begin
      n_err++;
      $display("FAIL pop_to_two: got cnt=%0d a=%h want 2 %h", count, a, exp[2].a);
    end
    cycle(1'b1, $urandom, $urandom, ALU_ADD, 1'b1, 1'b1);
    n_cmp++;
    if ({count, out_valid, in_ready, a, b, alucontrol} !== {3'd0, 1'b0, 1'b1, 64'd0, 3'd0}) begin
      n_err++;
      $display("FAIL flush_priority: got cnt=%0d ov=%b ir=%b a=%h b=%h op=%b want 0 0 1 0 0 0",
               count, out_valid, in_ready, a, b, alucontrol);
    end
  endtask

  task automatic test_stream_wrap();
    int   sent = 0;
    int   got = 0;
    int   cyc = 0;
    logic ordy = 1'b0;
    logic v, acc;
    while (got < 10 && cyc < 200) begin
      ordy = ~ordy;
      if (ordy && out_valid) begin
        n_cmp++;
        if ({a, b, alucontrol, result} !== {32'(got), 32'(got + 1), ALU_SUB, 32'hFFFF_FFFF}) begin
          n_err++;
          $display("FAIL stream[%0d]: got a=%h b=%h op=%b res=%h want %h %h 110 ffffffff", got,
                   a, b, alucontrol, result, 32'(got), 32'(got + 1));
        end
        got++;
      end
      v   = (sent < 10);
      acc = v && in_ready;
      cycle(v, 32'(sent), 32'(sent + 1), ALU_SUB, ordy, 1'b0);
      if (acc) sent++;
      cyc++;
    end
    n_cmp++;
    if (got != 10) begin
      n_err++;
      $display("FAIL stream_timeout: got %0d entries want 10", got);
    end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 3; i++) cycle(1'b1, $urandom, $urandom, 3'($urandom), 1'b0, 1'b0);
    n_cmp++;
    if (count !== 3'd3) begin
      n_err++;
      $display("FAIL async_prefill: got cnt=%0d want 3", count);
    end
    #1 reset_n = 1'b0;
    #1;
    n_cmp++;
    if ({count, out_valid, in_ready, a, alucontrol} !== {3'd0, 1'b0, 1'b1, 32'd0, 3'd0}) begin
      n_err++;
      $display("FAIL async_reset_immediate: got cnt=%0d ov=%b ir=%b a=%h op=%b want 0 0 1 0 0",
               count, out_valid, in_ready, a, alucontrol);
    end
    mq.delete();
    #2 reset_n = 1'b1;
    cycle(1'b1, 32'h0A, 32'h0B, ALU_SUB, 1'b0, 1'b0);
    n_cmp++;
    if ({count, a, b, alucontrol, result} !== {3'd1, 32'h0A, 32'h0B, ALU_SUB, 32'hFFFF_FFFF}) begin
      n_err++;
      $display("FAIL async_push_after_release: got cnt=%0d a=%h b=%h op=%b res=%h want 1 0a 0b 110 ffffffff",
               count, a, b, alucontrol, result);
    end
    cycle(1'b0, 32'd0, 32'd0, 3'd0, 1'b1, 1'b0);
  endtask

  task automatic test_random();
    ent_t        h;
    logic [31:0] ra, rb;
    logic [76:0] got_v, exp_v;
    for (int i = 0; i < 400; i++) begin
      h     = head_exp();
      exp_v = {3'(mq.size()), (mq.size() != 0), (mq.size() != DEPTH), h.a, h.b, h.op,
               ref_alu(h.a, h.b, h.op), (ref_alu(h.a, h.b, h.op) == 32'd0)};
      got_v = {count, out_valid, in_ready, a, b, alucontrol, result, zero};
      n_cmp++;
      if (got_v !== exp_v) begin
        n_err++;
        $display("FAIL random[%0d]: got {cnt,ov,ir,a,b,op,res,z}=%h want %h", i, got_v, exp_v);
      end
      ra = $urandom;
      rb = ($urandom_range(0, 3) == 0) ? ra : $urandom;
      cycle(($urandom_range(0, 9) < 6), ra, rb, 3'($urandom), 1'($urandom),
            ($urandom_range(0, 31) == 0));
    end
  endtask

  initial begin
    test_reset();
    test_slt();
    test_full();
    test_simul_and_flush();
    test_stream_wrap();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within 200000 time units");
    $fatal(1);
  end
endmodule
